// File: rtl/rd_stream_adapter.sv
// Read-side output stage of the async FIFO (rclk domain): turns the FIFO's registered
// read port into a valid/ready stream through a 2-entry prefetch/skid buffer.
module rd_stream_adapter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  r_rstn,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t                  occ;
  logic                  pf;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic                  push;
  logic [2:0]            level;

  assign pop   = m_valid & m_ready;
  assign push  = pf;

  // Entries held after this edge plus any read still in flight; must leave room for a new read.
  assign level = {1'b0, occ} + {2'b00, pf} - {2'b00, pop};

  assign fifo_ren  = r_rstn & ~fifo_empty & (level < 3'd2);
  assign occupancy = occ;

  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) begin
      occ      <= EMPTY;
      pf       <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      tail     <= '0;
      beat_cnt <= '0;
    end else begin
      pf <= fifo_ren;
      if (pop) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
      case (occ)
        EMPTY: begin
          if (push) begin
            m_data  <= fifo_rdata;
            m_valid <= 1'b1;
            occ     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            m_data <= fifo_rdata;
          end else if (push) begin
            tail <= fifo_rdata;
            occ  <= TWO;
          end else if (pop) begin
            m_valid <= 1'b0;
            occ     <= EMPTY;
          end
        end
        TWO: begin
          // Full buffer: a push can only arrive together with a pop.
          if (pop) begin
            m_data <= tail;
            if (push) begin
              tail <= fifo_rdata;
            end else begin
              occ <= ONE;
            end
          end
        end
        default: begin
          m_valid <= 1'b0;
          occ     <= EMPTY;
        end
      endcase
    end
  end

endmodule
